saida_serial_a0: RTL and testbench
==================================

SAIDA_SERIAL_A0 -- requirements
Module: saida_serial_a0

Interface
REQ-001 Parameter CICLOS_POR_BIT, default 16: Clock cycles each serial bit is held; legal range 2..65535.
REQ-002 Clock  input  1  system clock; all state updates on posedge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Dadoa0  input  8  value of register a0 (REG[7]) from the register bank's dedicated output.
REQ-005 Enviar  input  1  request to transmit the current Dadoa0.
REQ-006 Ocupado  output  1  high while a frame is in progress.
REQ-007 Concluido  output  1  one-cycle pulse when a frame has finished.
REQ-008 Tx  output  1  serial line; idles high.

Function
REQ-009 Frame: 1 start bit (0), 8 data bits LSB first, optional parity bit (REQ-021), 1 stop bit (1).
REQ-010 FSM states: OCIOSO, INICIO, DADOS, PARIDADE (present only with REQ-021), PARADA.
REQ-011 OCIOSO with Enviar=1 at a posedge: Dadoa0 captured into an 8-bit shift register; next state INICIO.
REQ-012 Tx, Ocupado and Concluido are registered outputs; Tx=0 and Ocupado=1 from the first cycle of INICIO, one cycle after Enviar is sampled.
REQ-013 Each state/bit lasts exactly CICLOS_POR_BIT cycles, timed by a bit-tick counter reloaded on every state/bit change.
REQ-014 DADOS: bit index 0..7; on each bit tick, shift right and increment the index; after bit 7, go to PARIDADE or PARADA.
REQ-015 After PARADA's last cycle: next state OCIOSO; Ocupado=0 and Concluido=1 for exactly that first OCIOSO cycle.
REQ-016 Enviar during any non-OCIOSO state is ignored (not queued); Dadoa0 changes after capture do not affect the frame.
REQ-017 Enviar held high: new frame captured at the first OCIOSO edge, so at least one idle-high cycle separates consecutive frames.
REQ-018 Frame length = 10*CICLOS_POR_BIT cycles (11*CICLOS_POR_BIT with parity), Enviar sample to Concluido pulse, +1 cycle.

Reset
REQ-019 Reset=1 at a posedge, including mid-frame: state OCIOSO, Tx=1, Ocupado=0, Concluido=0, counters and shift register = 0; the aborted frame is not resumed.
REQ-020 Reset has priority over Enviar in the same cycle.

Configuration
REQ-021 Macro SAIDA_SERIAL_PARIDADE_EN defined: PARIDADE state inserted after DADOS, Tx = even parity (XOR of the 8 captured bits) for CICLOS_POR_BIT cycles; undefined: no PARIDADE state, DADOS goes directly to PARADA, 10-bit frame.

Structure
REQ-022 Shared package holds the FSM state encoding constants (OCIOSO..PARADA) and frame-bit count constants; none are local to the module.
REQ-023 Bit-tick counter is a sub-module gerador_tick (parameter CICLOS_POR_BIT; inputs Clock, Reset, Reiniciar; output Tick), counter width = ceil(log2(CICLOS_POR_BIT)).

Verification (CICLOS_POR_BIT=4 unless stated)
REQ-024 Dadoa0=0xA5, Enviar pulse 1 cycle, no parity -> Tx sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1; Concluido pulse 41 cycles after the Enviar sample edge.
REQ-025 Parity on, Dadoa0=0x01 -> bits 0,1,0,0,0,0,0,0,0,1(parity),1; Dadoa0=0xA5 -> parity bit 0; frame 44 cycles.
REQ-026 Enviar re-pulsed mid-frame with Dadoa0 changed to 0x3C -> ignored; transmitted byte remains 0xA5; only one Concluido.
REQ-027 Reset asserted in DADOS bit 3 -> next cycle Tx=1, Ocupado=0; a subsequent Enviar with 0x5A transmits a complete correct frame.
REQ-028 Enviar held high for 3 frames, Dadoa0=0xFF -> three frames, each start bit preceded by exactly one idle-high cycle, three Concluido pulses.
REQ-029 CICLOS_POR_BIT=2 -> each bit lasts exactly 2 cycles; frame 20 cycles (22 with parity).

Source files
------------

// File: rtl/saida_serial_a0_pkg.sv
// Shared definitions for the saida_serial_a0 serial transmitter.
// Holds the FSM state encoding and the frame bit-count constants.
// Optional feature macro: SAIDA_SERIAL_PARIDADE_EN (adds an even-parity bit).
package saida_serial_a0_pkg;

  // PARIDADE is reachable only when SAIDA_SERIAL_PARIDADE_EN is defined.
  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    INICIO   = 3'd1,
    DADOS    = 3'd2,
    PARIDADE = 3'd3,
    PARADA   = 3'd4
  } estado_t;

  localparam int unsigned BITS_DADOS = 8;
  localparam logic [2:0]  ULTIMO_BIT = 3'(BITS_DADOS - 1);

`ifdef SAIDA_SERIAL_PARIDADE_EN
  localparam int unsigned BITS_QUADRO = 11;
`else
  localparam int unsigned BITS_QUADRO = 10;
`endif

endpackage

// File: rtl/saida_serial_a0_if.sv
// Handshake/data bundle between a requester and saida_serial_a0.
//   Dadoa0    : byte to transmit (register a0)
//   Enviar    : transmit request
//   Ocupado   : frame in progress
//   Concluido : one-cycle frame-done pulse
//   Tx        : serial line, idles high
// master = requester side, slave = transmitter side.
interface saida_serial_a0_if;
  logic [7:0] Dadoa0;
  logic       Enviar;
  logic       Ocupado;
  logic       Concluido;
  logic       Tx;

  modport master (
    output Dadoa0,
    output Enviar,
    input  Ocupado,
    input  Concluido,
    input  Tx
  );

  modport slave (
    input  Dadoa0,
    input  Enviar,
    output Ocupado,
    output Concluido,
    output Tx
  );
endinterface

// File: rtl/saida_serial_a0_gerador_tick.sv
// gerador_tick: bit-period counter for saida_serial_a0.
// Counts 0..CICLOS_POR_BIT-1; Tick is high on the last cycle of each period.
//   Clock     : system clock
//   Reset     : synchronous active-high reset
//   Reiniciar : reload the counter to 0 on the next edge
//   Tick      : last cycle of the current bit period
module gerador_tick #(
  parameter int unsigned CICLOS_POR_BIT = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Reiniciar,
  output logic Tick
);

  localparam int unsigned LARGURA = (CICLOS_POR_BIT > 1) ? $clog2(CICLOS_POR_BIT) : 1;
  localparam logic [LARGURA-1:0] ULTIMO = LARGURA'(CICLOS_POR_BIT - 1);

  logic [LARGURA-1:0] contagemQ, contagemD;

  assign Tick = (contagemQ == ULTIMO);

  always_comb begin
    contagemD = contagemQ + 1'b1;
    if (Reiniciar) begin
      contagemD = '0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      contagemQ <= '0;
    end else begin
      contagemQ <= contagemD;
    end
  end

endmodule

// File: rtl/saida_serial_a0.sv
// saida_serial_a0: transmits register a0 as an asynchronous serial frame.
// Frame: start (0), 8 data bits LSB first, optional even parity, stop (1).
// Each bit lasts CICLOS_POR_BIT clocks. Define SAIDA_SERIAL_PARIDADE_EN to add
// the parity bit (11-bit frame); otherwise the frame is 10 bits.
//   Clock  : system clock
//   Reset  : synchronous active-high reset
//   serial : saida_serial_a0_if.slave (Dadoa0, Enviar in; Ocupado, Concluido, Tx out)
module saida_serial_a0
  import saida_serial_a0_pkg::*;
#(
  parameter int unsigned CICLOS_POR_BIT = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  saida_serial_a0_if.slave      serial
);

  estado_t    estadoQ, estadoD;
  logic [2:0] indiceQ, indiceD;
  logic [7:0] deslocQ, deslocD;
  logic       txQ, txD;
  logic       ocupadoQ, ocupadoD;
  logic       concluidoQ, concluidoD;
  logic       tick;
  logic       reiniciar;
  logic       bitParidade;

`ifdef SAIDA_SERIAL_PARIDADE_EN
  logic       paridadeQ, paridadeD;
  assign bitParidade = paridadeQ;
`else
  assign bitParidade = 1'b1;
`endif

  // Held at zero while idle so the start bit gets a full period; the wrap on
  // each tick restarts the period at every bit/state change.
  assign reiniciar = (estadoQ == OCIOSO) || tick;

  gerador_tick #(
    .CICLOS_POR_BIT(CICLOS_POR_BIT)
  ) uTick (
    .Clock    (Clock),
    .Reset    (Reset),
    .Reiniciar(reiniciar),
    .Tick     (tick)
  );

  always_comb begin
    estadoD = estadoQ;
    indiceD = indiceQ;
    deslocD = deslocQ;
`ifdef SAIDA_SERIAL_PARIDADE_EN
    paridadeD = paridadeQ;
`endif
    case (estadoQ)
      OCIOSO: begin
        if (serial.Enviar) begin
          estadoD = INICIO;
          deslocD = serial.Dadoa0;
          indiceD = '0;
`ifdef SAIDA_SERIAL_PARIDADE_EN
          paridadeD = ^serial.Dadoa0;
`endif
        end
      end
      INICIO: begin
        if (tick) begin
          estadoD = DADOS;
          indiceD = '0;
        end
      end
      DADOS: begin
        if (tick) begin
          deslocD = deslocQ >> 1;
          indiceD = indiceQ + 3'd1;
          if (indiceQ == ULTIMO_BIT) begin
`ifdef SAIDA_SERIAL_PARIDADE_EN
            estadoD = PARIDADE;
`else
            estadoD = PARADA;
`endif
          end
        end
      end
      PARIDADE: begin
        if (tick) begin
          estadoD = PARADA;
        end
      end
      PARADA: begin
        if (tick) begin
          estadoD = OCIOSO;
        end
      end
      default: estadoD = OCIOSO;
    endcase

    // Outputs are registered from the next state so they line up with it.
    txD = 1'b1;
    case (estadoD)
      INICIO:   txD = 1'b0;
      DADOS:    txD = deslocD[0];
      PARIDADE: txD = bitParidade;
      default:  txD = 1'b1;
    endcase
    ocupadoD   = (estadoD != OCIOSO);
    concluidoD = (estadoQ == PARADA) && (estadoD == OCIOSO);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      estadoQ    <= OCIOSO;
      indiceQ    <= '0;
      deslocQ    <= '0;
      txQ        <= 1'b1;
      ocupadoQ   <= 1'b0;
      concluidoQ <= 1'b0;
`ifdef SAIDA_SERIAL_PARIDADE_EN
      paridadeQ  <= 1'b0;
`endif
    end else begin
      estadoQ    <= estadoD;
      indiceQ    <= indiceD;
      deslocQ    <= deslocD;
      txQ        <= txD;
      ocupadoQ   <= ocupadoD;
      concluidoQ <= concluidoD;
`ifdef SAIDA_SERIAL_PARIDADE_EN
      paridadeQ  <= paridadeD;
`endif
    end
  end

  assign serial.Tx        = txQ;
  assign serial.Ocupado   = ocupadoQ;
  assign serial.Concluido = concluidoQ;

endmodule

// File: tb/tb_saida_serial_a0.sv
// Bench for saida_serial_a0: DUT A with 4 cycles/bit, DUT B with 2 cycles/bit.
module tb_saida_serial_a0;

  typedef struct packed {
    logic [7:0] dado;
    logic [9:0] quadro;  // start, d0..d7, stop; bit 9 goes out first
    logic       par;     // even parity of dado
  } vetor_t;

`ifdef SAIDA_SERIAL_PARIDADE_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic Clock = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;
  int   sel    = 0;

  always #5 Clock = ~Clock;

  saida_serial_a0_if busA ();
  saida_serial_a0_if busB ();

  saida_serial_a0 #(.CICLOS_POR_BIT(4)) dutA (
    .Clock (Clock),
    .Reset (Reset),
    .serial(busA.slave)
  );

  saida_serial_a0 #(.CICLOS_POR_BIT(2)) dutB (
    .Clock (Clock),
    .Reset (Reset),
    .serial(busB.slave)
  );

  task automatic compara(input string nome, input logic atual, input logic esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nome, atual, esperado, $time);
    end
  endtask

  function automatic logic txSel();
    return (sel != 0) ? busB.Tx : busA.Tx;
  endfunction
  function automatic logic ocSel();
    return (sel != 0) ? busB.Ocupado : busA.Ocupado;
  endfunction
  function automatic logic coSel();
    return (sel != 0) ? busB.Concluido : busA.Concluido;
  endfunction

  task automatic setIn(input logic env, input logic [7:0] d);
    if (sel != 0) begin
      busB.Enviar = env;
      busB.Dadoa0 = d;
    end else begin
      busA.Enviar = env;
      busA.Dadoa0 = d;
    end
  endtask

  // Requests one frame and checks every cycle of it plus the Concluido pulse.
  task automatic enviaQuadro(input int n, input vetor_t v, input bit manter,
                             input bit interfere, input string nome);
    logic seq[0:10];
    for (int i = 0; i < 9; i++) seq[i] = v.quadro[9-i];
    if (NBITS == 11) begin
      seq[9]  = v.par;
      seq[10] = 1'b1;
    end else begin
      seq[9]  = 1'b1;
      seq[10] = 1'b1;
    end
    @(negedge Clock);
    setIn(1'b1, v.dado);
    @(posedge Clock);
    #1;
    if (!manter) setIn(1'b0, ~v.dado);  // late data change must not matter
    for (int k = 0; k < NBITS * n; k++) begin
      if (interfere && k == 10) setIn(1'b1, 8'h3C);
      if (interfere && k == 11) setIn(1'b0, 8'h3C);
      compara($sformatf("%s tx k=%0d", nome, k), txSel(), seq[k / n]);
      compara($sformatf("%s ocupado k=%0d", nome, k), ocSel(), 1'b1);
      compara($sformatf("%s concluido k=%0d", nome, k), coSel(), 1'b0);
      @(posedge Clock);
      #1;
    end
    compara($sformatf("%s concluido end", nome), coSel(), 1'b1);
    compara($sformatf("%s ocupado end", nome), ocSel(), 1'b0);
    compara($sformatf("%s tx idle", nome), txSel(), 1'b1);
    if (!manter) begin
      @(posedge Clock);
      #1;
      compara($sformatf("%s concluido single", nome), coSel(), 1'b0);
      compara($sformatf("%s tx idle2", nome), txSel(), 1'b1);
    end
  endtask

  vetor_t tabela[7];

  initial begin
    tabela[0] = '{dado: 8'hA5, quadro: 10'b0101001011, par: 1'b0};
    tabela[1] = '{dado: 8'h01, quadro: 10'b0100000001, par: 1'b1};
    tabela[2] = '{dado: 8'h00, quadro: 10'b0000000001, par: 1'b0};
    tabela[3] = '{dado: 8'hFF, quadro: 10'b0111111111, par: 1'b0};
    tabela[4] = '{dado: 8'h80, quadro: 10'b0000000011, par: 1'b1};
    tabela[5] = '{dado: 8'h3C, quadro: 10'b0001111001, par: 1'b0};
    tabela[6] = '{dado: 8'h5A, quadro: 10'b0010110101, par: 1'b0};

    Reset = 1'b1;
    busA.Enviar = 1'b0; busA.Dadoa0 = 8'h00;
    busB.Enviar = 1'b0; busB.Dadoa0 = 8'h00;
    repeat (3) @(posedge Clock);
    #1;
    compara("reset txA", busA.Tx, 1'b1);
    compara("reset ocupadoA", busA.Ocupado, 1'b0);
    compara("reset concluidoA", busA.Concluido, 1'b0);
    compara("reset txB", busB.Tx, 1'b1);
    compara("reset ocupadoB", busB.Ocupado, 1'b0);
    @(negedge Clock);
    Reset = 1'b0;

    // Table-driven frames at 4 cycles/bit.
    sel = 0;
    for (int i = 0; i < 7; i++) begin
      enviaQuadro(4, tabela[i], 1'b0, 1'b0, $sformatf("vec%0d", i));
    end

    // Mid-frame re-request with new data is ignored.
    enviaQuadro(4, tabela[0], 1'b0, 1'b1, "interfere");

    // Enviar held: three back-to-back frames, one idle cycle between them.
    enviaQuadro(4, tabela[3], 1'b1, 1'b0, "held1");
    enviaQuadro(4, tabela[3], 1'b1, 1'b0, "held2");
    enviaQuadro(4, tabela[3], 1'b0, 1'b0, "held3");

    // Reset during DADOS bit 3, then a clean frame.
    @(negedge Clock);
    setIn(1'b1, 8'hA5);
    @(posedge Clock);
    #1;
    setIn(1'b0, 8'hA5);
    repeat (17) @(posedge Clock);
    #1;
    compara("abort ocupado before", busA.Ocupado, 1'b1);
    compara("abort bit3 value", busA.Tx, 1'b0);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    compara("abort tx", busA.Tx, 1'b1);
    compara("abort ocupado", busA.Ocupado, 1'b0);
    compara("abort concluido", busA.Concluido, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(posedge Clock);
      #1;
      compara($sformatf("abort no resume k=%0d", k), busA.Ocupado, 1'b0);
    end
    enviaQuadro(4, tabela[6], 1'b0, 1'b0, "after abort");

    // Reset wins over Enviar in the same cycle.
    @(negedge Clock);
    Reset = 1'b1;
    setIn(1'b1, 8'hFF);
    @(posedge Clock);
    #1;
    compara("prio ocupado", busA.Ocupado, 1'b0);
    compara("prio tx", busA.Tx, 1'b1);
    @(negedge Clock);
    Reset = 1'b0;
    setIn(1'b0, 8'hFF);
    @(posedge Clock);
    #1;
    compara("prio stays idle", busA.Ocupado, 1'b0);

    // 2 cycles/bit instance.
    sel = 1;
    enviaQuadro(2, tabela[0], 1'b0, 1'b0, "fast A5");
    enviaQuadro(2, tabela[1], 1'b0, 1'b0, "fast 01");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
